transfer: RTL and testbench

TRANSFER -- requirements
Module: transfer

---
 rtl/transfer.sv | 126 ++++++++++++
 tb/tb_transfer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/transfer.sv
// Four-channel word-to-UART framer: fixed-priority grant, then a 5-byte 8N1 frame
// (header A0|chan, then the latched word LSB first) at BAUD_PRESCALER clocks per bit.
module transfer #(
  parameter int unsigned BAUD_PRESCALER = 104
) (
  input  logic         i_clk,
  input  logic         _rst,
  input  logic [127:0] data_in,
  input  logic [3:0]   available,
  output logic [3:0]   read,
  output logic         tx,
  output logic         busy
);

  localparam int unsigned CW = (BAUD_PRESCALER > 2) ? $clog2(BAUD_PRESCALER) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_PRESCALER - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_idx;
  logic [31:0]   word;
  logic [1:0]    chan;

  logic [1:0]    gnt_c;
  logic [7:0]    cur_byte_c;
  logic          baud_done_c;

  // Fixed priority: lowest set index wins.
  always_comb begin
    gnt_c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (available[i]) gnt_c = 2'(i);
    end
  end

  always_comb begin
    cur_byte_c = 8'h00;
    case (byte_idx)
      3'd0:    cur_byte_c = 8'hA0 | {6'd0, chan};
      3'd1:    cur_byte_c = word[7:0];
      3'd2:    cur_byte_c = word[15:8];
      3'd3:    cur_byte_c = word[23:16];
      default: cur_byte_c = word[31:24];
    endcase
  end

  assign baud_done_c = (baud == BAUD_LAST);

  // tx is updated on the same edge as the state so each bit holds exactly one baud period.
  always_ff @(posedge i_clk) begin
    if (!_rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= 3'd0;
      byte_idx <= 3'd0;
      word     <= 32'd0;
      chan     <= 2'd0;
      read     <= 4'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      read <= 4'd0;
      case (state)
        IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
          busy <= 1'b0;
          if (|available) begin
            chan     <= gnt_c;
            word     <= data_in[{gnt_c, 5'd0} +: 32];
            read     <= 4'b0001 << gnt_c;
            byte_idx <= 3'd0;
            bit_cnt  <= 3'd0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baud_done_c) begin
            baud    <= '0;
            bit_cnt <= 3'd0;
            state   <= DATA;
            tx      <= cur_byte_c[0];
          end else begin
            baud <= baud + CW'(1);
          end
        end
        DATA: begin
          if (baud_done_c) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte_c[bit_cnt + 3'd1];
            end
          end else begin
            baud <= baud + CW'(1);
          end
        end
        default: begin
          if (baud_done_c) begin
            baud <= '0;
            if (byte_idx < 3'd4) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            baud <= baud + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transfer.sv
// Directed bench for transfer at BAUD_PRESCALER=5: samples tx mid-bit and decodes frames.
module tb_transfer;

  localparam int unsigned P = 5;
  localparam logic [127:0] WORDS = 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD;

  logic         clk;
  logic         rst_n;
  logic [127:0] data_in;
  logic [3:0]   available;
  logic [3:0]   read;
  logic         tx;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  transfer #(.BAUD_PRESCALER(P)) dut (
    .i_clk    (clk),
    ._rst     (rst_n),
    .data_in  (data_in),
    .available(available),
    .read     (read),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step negedges until read is non-zero or the budget runs out.
  task automatic wait_read(input string tag, input logic [3:0] exp, input int budget,
                           output int waited);
    waited = 0;
    while (read == 4'd0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_read"}, 32'(read), 32'(exp));
  endtask

  // Entered at the negedge of the first START cycle; leaves at the negedge of the first IDLE cycle.
  task automatic rx_frame(input string tag, input logic [7:0] hdr, input logic [31:0] w);
    logic [49:0] bits;
    logic [7:0]  b;
    logic [7:0]  eb;
    bits = '0;
    for (int c = 0; c < 50 * int'(P); c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) check({tag, "_read_pulse"}, 32'(read), 32'd0);
      if (c % int'(P) == 2) bits[c / int'(P)] = tx;
      if (c == 50 * int'(P) - 1) check({tag, "_busy_last"}, 32'(busy), 32'd1);
    end
    @(negedge clk);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_tx_end"}, 32'(tx), 32'd1);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) b[j] = bits[10 * k + 1 + j];
      eb = (k == 0) ? hdr : w[8 * (k - 1) +: 8];
      check($sformatf("%s_b%0d_start", tag, k), 32'(bits[10 * k]), 32'd0);
      check($sformatf("%s_b%0d_data", tag, k), 32'(b), 32'(eb));
      check($sformatf("%s_b%0d_stop", tag, k), 32'(bits[10 * k + 9]), 32'd1);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_read"}, 32'(read), 32'd0);
  endtask

  int waited;

  initial begin
    rst_n     = 1'b0;
    data_in   = WORDS;
    available = 4'd0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Idle with nothing pending.
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(negedge clk);
      check_idle("idle");
    end

    // Single channel 2.
    available = 4'b0100;
    wait_read("single", 4'b0100, 20, waited);
    check("single_latency", 32'(waited), 32'd1);
    available = 4'd0;
    rx_frame("single", 8'hA2, 32'hBBBBBBBB);

    // Priority: 0 beats 3, then 3 follows after one IDLE cycle.
    available = 4'b1001;
    wait_read("prio0", 4'b0001, 20, waited);
    available = 4'b1000;
    rx_frame("prio0", 8'hA0, 32'hDDDDDDDD);
    wait_read("prio3", 4'b1000, 20, waited);
    check("prio3_gap", 32'(waited), 32'd1);
    available = 4'd0;
    rx_frame("prio3", 8'hA3, 32'hAAAAAAAA);

    // Held request: back-to-back frames, one IDLE cycle between them (251-cycle grant interval).
    available = 4'b0100;
    wait_read("held0", 4'b0100, 20, waited);
    for (int f = 0; f < 4; f++) begin
      if (f == 3) available = 4'd0;
      rx_frame($sformatf("held%0d", f), 8'hA2, 32'hBBBBBBBB);
      if (f < 3) begin
        wait_read($sformatf("held%0d", f + 1), 4'b0100, 20, waited);
        check($sformatf("held%0d_gap", f + 1), 32'(waited), 32'd1);
      end
    end
    repeat (5) @(negedge clk);
    check_idle("held_done");

    // Data change mid-frame must not affect the latched word.
    available = 4'b0001;
    wait_read("chg", 4'b0001, 20, waited);
    available = 4'd0;
    data_in   = 128'h11112222333344445555666677778888;
    rx_frame("chg", 8'hA0, 32'hDDDDDDDD);
    data_in = WORDS;

    // Reset during DATA bits of byte 2 (frame cycles 105..144).
    available = 4'b0010;
    wait_read("rst", 4'b0010, 20, waited);
    available = 4'd0;
    repeat (120) @(negedge clk);
    check("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
    rst_n     = 1'b1;
    available = 4'b0010;
    wait_read("rst_after", 4'b0010, 20, waited);
    available = 4'd0;
    rx_frame("rst_after", 8'hA1, 32'hCCCCCCCC);

    repeat (10) @(negedge clk);
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
